// File: rtl/serial_pattern_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_pattern_feeder: double-buffered parallel-to-serial feeder for the |
// | 11011 sequence detector.                        Revision 1.0 (initial)   |
// +--------------------------------------------------------------------------+
module serial_pattern_feeder #(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);
  localparam logic [0:0]      S_IDLE   = 1'b0;
  localparam logic [0:0]      S_SHIFT  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             word_done_q, word_done_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic [WIDTH-1:0] shift_adv;
  logic             next_bit;

  assign data_ready = !hold_full_q && !rst;
  assign accept     = data_valid && data_ready;

  // Bit order only changes which end of the shifter is presented on out.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shift_adv = {shift_q[WIDTH-2:0], 1'b0};
      assign next_bit  = shift_d[WIDTH-1];
    end else begin : g_lsb_first
      assign shift_adv = {1'b0, shift_q[WIDTH-1:1]};
      assign next_bit  = shift_d[0];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d = data_in;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      default: begin
        if (cnt_q == LAST_CNT) begin
          // ready is low while the hold is full, so drain and accept never collide
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
          end else if (accept) begin
            shift_d = data_in;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          shift_d = shift_adv;
          if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end
        end
      end
    endcase
  end

  assign out_valid_d = (state_d == S_SHIFT);
  assign out_d       = out_valid_d ? next_bit : IDLE_BIT;
  assign word_done_d = out_valid_d && (cnt_d == LAST_CNT);
  assign busy_d      = out_valid_d || hold_full_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      out_q       <= IDLE_BIT;
      out_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      word_done_q <= word_done_d;
      busy_q      <= busy_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign word_done = word_done_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_feeder.sv
`default_nettype none
// Testbench for serial_pattern_feeder: an MSB-first and an LSB-first instance share
// one producer and are compared every cycle against a two-entry word queue model.
module tb_serial_pattern_feeder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         dv;
  logic [W-1:0] din;
  logic rdy_a, out_a, ov_a, busy_a, wd_a;
  logic rdy_b, out_b, ov_b, busy_b, wd_b;

  always #5 clk = ~clk;

  serial_pattern_feeder #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_a (
    .clk(clk), .rst(rst), .data_in(din), .data_valid(dv), .data_ready(rdy_a),
    .out(out_a), .out_valid(ov_a), .busy(busy_a), .word_done(wd_a)
  );

  serial_pattern_feeder #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(1'b1)) u_b (
    .clk(clk), .rst(rst), .data_in(din), .data_valid(dv), .data_ready(rdy_b),
    .out(out_b), .out_valid(ov_b), .busy(busy_b), .word_done(wd_b)
  );

  int tests  = 0;
  int errors = 0;

  // Model: words accepted but not fully sent; entry 0 is on the wire at bit index mpos.
  logic [W-1:0] mq[$];
  int           mpos = 0;
  bit           last_acc = 1'b0;

  logic [63:0] cap_a, cap_b;
  int          ncap_a, ncap_b;

  function automatic logic mbit(input logic [W-1:0] w, input int pos, input bit msb);
    return msb ? w[W-1-pos] : w[pos];
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_caps();
    cap_a = '0; cap_b = '0; ncap_a = 0; ncap_b = 0;
  endtask

  task automatic tick();
    bit   mready;
    logic ev;
    @(posedge clk);
    mready   = (mq.size() < 2) && !rst;
    last_acc = dv && mready;
    if (rst) begin
      mq.delete();
      mpos = 0;
    end else begin
      if (mq.size() > 0) begin
        mpos++;
        if (mpos == W) begin
          void'(mq.pop_front());
          mpos = 0;
        end
      end
      if (last_acc) mq.push_back(din);
    end
    #1;
    ev = (mq.size() > 0);
    check("out_a",   out_a,  ev ? mbit(mq[0], mpos, 1'b1) : 1'b0);
    check("out_b",   out_b,  ev ? mbit(mq[0], mpos, 1'b0) : 1'b1);
    check("valid_a", ov_a,   ev);
    check("valid_b", ov_b,   ev);
    check("done_a",  wd_a,   ev && (mpos == W-1));
    check("done_b",  wd_b,   ev && (mpos == W-1));
    check("busy_a",  busy_a, ev);
    check("busy_b",  busy_b, ev);
    check("ready_a", rdy_a,  !rst && (mq.size() < 2));
    check("ready_b", rdy_b,  !rst && (mq.size() < 2));
    if (ov_a) begin cap_a = {cap_a[62:0], out_a}; ncap_a++; end
    if (ov_b) begin cap_b = {cap_b[62:0], out_b}; ncap_b++; end
  endtask

  // Presents a word and keeps valid high until it is taken (bounded wait).
  task automatic send(input logic [W-1:0] w);
    int n;
    n   = 0;
    din = w;
    dv  = 1'b1;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 40);
    check("send_accept", last_acc, 1'b1);
  endtask

  initial begin
    rst = 1'b1; dv = 1'b0; din = '0;
    clear_caps();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("ready_after_rst", rdy_a, 1'b1);

    // Single word, MSB first on u_a
    clear_caps();
    send(8'b11011000);
    dv = 1'b0;
    repeat (10) tick();
    check_vec("single_bits_a", cap_a, 64'hD8);
    check("single_count_a", ncap_a == 8, 1'b1);

    // Back-to-back words through the hold register
    clear_caps();
    send(8'hDB);
    send(8'h6C);
    check("b2b_ready_low", rdy_a, 1'b0);
    dv = 1'b0;
    repeat (18) tick();
    check_vec("b2b_bits_a", cap_a, 64'hDB6C);
    check("b2b_count_a", ncap_a == 16, 1'b1);

    // Backpressure: third word waits for the hold to drain
    clear_caps();
    send(8'hA5);
    send(8'h3C);
    send(8'hE7);
    dv = 1'b0;
    repeat (26) tick();
    check_vec("bp_bits_a", cap_a, 64'hA53CE7);
    check("bp_count_a", ncap_a == 24, 1'b1);

    // LSB-first instance sees 1,1,0,1,1,0,0,0
    clear_caps();
    send(8'b00011011);
    dv = 1'b0;
    repeat (10) tick();
    check_vec("lsb_bits_b", cap_b, 64'hD8);

    // Reset while the 4th bit is out and a second word is held
    send(8'hFF);
    send(8'h81);
    dv = 1'b0;
    tick();
    tick();
    check("mid_bit4_valid", ov_a, 1'b1);
    clear_caps();
    rst = 1'b1;
    tick();
    check("rst_out_b_idle", out_b, 1'b1);
    rst = 1'b0;
    #1;
    check("rst_ready_after", rdy_a, 1'b1);
    repeat (12) tick();
    check("rst_no_stale_a", ncap_a == 0, 1'b1);
    check("rst_no_stale_b", ncap_b == 0, 1'b1);

    // Accept exactly on the last-bit edge with the hold empty
    clear_caps();
    send(8'h5A);
    dv = 1'b0;
    repeat (W-1) tick();
    check("last_bit_done", wd_a, 1'b1);
    din = 8'hC3;
    dv  = 1'b1;
    tick();
    check("last_edge_acc", last_acc, 1'b1);
    check("last_edge_hold_empty", rdy_a, 1'b1);
    dv = 1'b0;
    repeat (10) tick();
    check_vec("last_edge_bits_a", cap_a, 64'h5AC3);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if (!(dv && (mq.size() >= 2))) begin
        dv  = ($urandom_range(0, 2) != 0);
        din = W'($urandom);
      end
      rst = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0;
    dv  = 1'b0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
